// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified-memory arbiter: the arbiter state encoding,
// default address/data widths, requester identifiers and the wait-counter
// saturation value.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int ADDR_W_DFLT = 32;
   localparam int DATA_W_DFLT = 32;

   // Requester identifiers used by the grant selection.
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_DM = 1'b1;

   localparam logic [31:0] WAIT_CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_perf_cnt
// One saturating 32-bit wait counter. Counts every cycle in which en_i is high
// and sticks at 0xFFFF_FFFF. Only built when ARB_PERF_EN is defined, so the
// default build carries no counter logic at all.
//
// Ports:
//   clk_i  in   clock, rising edge
//   rst_i  in   asynchronous active-low reset (clears the count)
//   en_i   in   count enable for this cycle
//   cnt_o  out  current count
// -----------------------------------------------------------------------------
`ifdef ARB_PERF_EN
module mem_arb_perf_cnt
   import mem_arb_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   output logic [31:0] cnt_o
);

   logic [31:0] cnt_d;
   logic [31:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != WAIT_CNT_MAX)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between the instruction-fetch (IF) and
// data-memory (DM) stages. DM has priority; one access is in flight at a time
// and runs to the memory ack without preemption. Completion is reported with a
// one-cycle rdy pulse the cycle after the ack; during that pulse the answered
// requester is masked so its stale request is not granted again.
//
// Optional feature: define ARB_PERF_EN to add if_wait_cnt_o / dm_wait_cnt_o,
// saturating counts of cycles each requester spent waiting.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   start_i                      grant enable (in-flight access still completes)
//   if_req_i, if_addr_i          fetch request (level) and address
//   if_rdy_o, if_data_o          fetch done pulse, fetched word (held)
//   dm_req_i, dm_we_i,
//   dm_addr_i, dm_wdata_i        data request (level), write flag, addr, wdata
//   dm_rdy_o, dm_rdata_o         data done pulse, read word (held)
//   stall_o                      pipeline stall while a request is unanswered
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o      memory request and latched access fields
//   mem_rdata_i, mem_ack_i       memory read data and completion pulse
//   if_wait_cnt_o, dm_wait_cnt_o (ARB_PERF_EN only) wait-cycle counters
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_rdy_o,
   output logic [DATA_W-1:0] if_data_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_rdy_o,
   output logic [DATA_W-1:0] dm_rdata_o,
`ifdef ARB_PERF_EN
   output logic [31:0]       if_wait_cnt_o,
   output logic [31:0]       dm_wait_cnt_o,
`endif
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   arb_state_e        state_d, state_q;
   logic              if_rdy_d, if_rdy_q;
   logic              dm_rdy_d, dm_rdy_q;
   logic              mem_req_d, mem_req_q;
   logic              mem_we_d, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
   logic [DATA_W-1:0] if_data_d, if_data_q;
   logic [DATA_W-1:0] dm_rdata_d, dm_rdata_q;

   logic if_wait, dm_wait;
   logic gnt_vld, gnt_id;

   // A requester whose rdy pulse is showing this cycle is holding a stale
   // request; it is not eligible until the pulse is gone.
   assign dm_wait = dm_req_i & ~dm_rdy_q;
   assign if_wait = if_req_i & ~if_rdy_q;
   assign gnt_vld = start_i & (dm_wait | if_wait);
   assign gnt_id  = dm_wait ? REQ_DM : REQ_IF;

   always_comb begin
      state_d     = state_q;
      if_rdy_d    = 1'b0;
      dm_rdy_d    = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_data_d   = if_data_q;
      dm_rdata_d  = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               mem_req_d = 1'b1;
               if (gnt_id == REQ_DM) begin
                  state_d     = BUSY_DM;
                  mem_addr_d  = dm_addr_i;
                  mem_we_d    = dm_we_i;
                  mem_wdata_d = dm_wdata_i;
               end else begin
                  state_d    = BUSY_IF;
                  mem_addr_d = if_addr_i;
                  mem_we_d   = 1'b0;
               end
            end
         end
         BUSY_IF: begin
            if (mem_ack_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if_data_d = mem_rdata_i;
               if_rdy_d  = 1'b1;
            end
         end
         BUSY_DM: begin
            if (mem_ack_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               dm_rdy_d  = 1'b1;
               if (!mem_we_q) begin
                  dm_rdata_d = mem_rdata_i;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         if_rdy_q    <= 1'b0;
         dm_rdy_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_data_q   <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         if_rdy_q    <= if_rdy_d;
         dm_rdy_q    <= dm_rdy_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_data_q   <= if_data_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign if_rdy_o    = if_rdy_q;
   assign dm_rdy_o    = dm_rdy_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_data_o   = if_data_q;
   assign dm_rdata_o  = dm_rdata_q;

   // Stall is combinational from the live requests; it is forced low while
   // reset is asserted so the pipeline sees a quiet arbiter during reset.
   assign stall_o = rst_i & (if_wait | dm_wait);

`ifdef ARB_PERF_EN
   mem_arb_perf_cnt u_if_wait (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (if_wait),
      .cnt_o (if_wait_cnt_o)
   );

   mem_arb_perf_cnt u_dm_wait (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (dm_wait),
      .cnt_o (dm_wait_cnt_o)
   );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int NONE   = 0;
   localparam int OWN_IF = 1;
   localparam int OWN_DM = 2;

   logic        clk = 1'b0;
   logic        rst_i, start_i;
   logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
   logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
   logic        if_rdy_o, dm_rdy_o, stall_o, mem_req_o, mem_we_o;
   logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
`ifdef ARB_PERF_EN
   logic [31:0] if_wait_cnt_o, dm_wait_cnt_o;
`endif

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_rdy_o    (if_rdy_o),
      .if_data_o   (if_data_o),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_rdy_o    (dm_rdy_o),
      .dm_rdata_o  (dm_rdata_o),
`ifdef ARB_PERF_EN
      .if_wait_cnt_o (if_wait_cnt_o),
      .dm_wait_cnt_o (dm_wait_cnt_o),
`endif
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Memory contents as seen by the bench; unwritten words read a hash of
   // their address.
   logic [31:0] mem_m [logic [31:0]];

   // Reference model: which requester owns the memory, the fields it was
   // granted with, and what each output should show.
   int          act;
   logic [31:0] act_addr, act_wdata;
   logic        act_we;
   int          wait_left;
   int          force_wait = -1;
   logic [31:0] ack_data;
   logic        e_if_rdy, e_dm_rdy;
   logic [31:0] e_if_data, e_dm_rdata;
   logic [31:0] e_if_cnt, e_dm_cnt;
   logic        if_done, dm_done;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      act        = NONE;
      act_addr   = '0;
      act_wdata  = '0;
      act_we     = 1'b0;
      wait_left  = 0;
      e_if_rdy   = 1'b0;
      e_dm_rdy   = 1'b0;
      e_if_data  = '0;
      e_dm_rdata = '0;
      e_if_cnt   = '0;
      e_dm_cnt   = '0;
      if_done    = 1'b0;
      dm_done    = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_if_rdy",    if_rdy_o,    0);
      chk("rst_dm_rdy",    dm_rdy_o,    0);
      chk("rst_mem_req",   mem_req_o,   0);
      chk("rst_mem_we",    mem_we_o,    0);
      chk("rst_stall",     stall_o,     0);
      chk("rst_mem_addr",  mem_addr_o,  0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_if_data",   if_data_o,   0);
      chk("rst_dm_rdata",  dm_rdata_o,  0);
`ifdef ARB_PERF_EN
      chk("rst_if_cnt",    if_wait_cnt_o, 0);
      chk("rst_dm_cnt",    dm_wait_cnt_o, 0);
`endif
   endtask

   task automatic do_reset();
      rst_i = 1'b0; start_i = 1'b0;
      if_req_i = 1'b0; if_addr_i = '0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals();
      rst_i = 1'b1;
      model_reset();
   endtask

   function automatic int pick_wait();
      if (force_wait >= 0) return force_wait;
      return int'($urandom_range(0, 3));
   endfunction

   // One clock: advance the model by the rules of arbitration, compare every
   // output, then play the memory for the following cycle.
   task automatic tick();
      logic p_start, p_if_req, p_dm_req, p_ack, p_if_rdy, p_dm_rdy;
      p_start  = start_i;
      p_if_req = if_req_i;
      p_dm_req = dm_req_i;
      p_ack    = mem_ack_i;
      p_if_rdy = e_if_rdy;
      p_dm_rdy = e_dm_rdy;
      @(posedge clk);
      #1;
      if (p_if_req && !p_if_rdy && e_if_cnt != 32'hFFFF_FFFF) e_if_cnt = e_if_cnt + 32'd1;
      if (p_dm_req && !p_dm_rdy && e_dm_cnt != 32'hFFFF_FFFF) e_dm_cnt = e_dm_cnt + 32'd1;
      e_if_rdy = 1'b0;
      e_dm_rdy = 1'b0;
      if (act != NONE) begin
         if (p_ack) begin
            if (act == OWN_IF) begin
               e_if_rdy  = 1'b1;
               e_if_data = ack_data;
            end else begin
               e_dm_rdy = 1'b1;
               if (!act_we) e_dm_rdata = ack_data;
            end
            act = NONE;
         end
      end else if (p_start && p_dm_req && !p_dm_rdy) begin
         act = OWN_DM; act_addr = dm_addr_i; act_we = dm_we_i; act_wdata = dm_wdata_i;
         wait_left = pick_wait();
      end else if (p_start && p_if_req && !p_if_rdy) begin
         act = OWN_IF; act_addr = if_addr_i; act_we = 1'b0;
         wait_left = pick_wait();
      end

      chk("mem_req", mem_req_o, act != NONE);
      if (act != NONE) begin
         chk("mem_addr", mem_addr_o, act_addr);
         chk("mem_we",   mem_we_o,   act_we);
         if (act == OWN_DM) chk("mem_wdata", mem_wdata_o, act_wdata);
      end
      chk("if_rdy",   if_rdy_o,   e_if_rdy);
      chk("dm_rdy",   dm_rdy_o,   e_dm_rdy);
      chk("if_data",  if_data_o,  e_if_data);
      chk("dm_rdata", dm_rdata_o, e_dm_rdata);
      chk("stall",    stall_o,    (if_req_i && !e_if_rdy) || (dm_req_i && !e_dm_rdy));
`ifdef ARB_PERF_EN
      chk("if_wait_cnt", if_wait_cnt_o, e_if_cnt);
      chk("dm_wait_cnt", dm_wait_cnt_o, e_dm_cnt);
`endif

      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
      if (act != NONE) begin
         if (wait_left == 0) begin
            mem_ack_i = 1'b1;
            if (act_we) begin
               mem_m[act_addr] = act_wdata;
            end else begin
               ack_data    = mem_rd(act_addr);
               mem_rdata_i = ack_data;
            end
         end else begin
            wait_left--;
         end
      end else if ($urandom_range(0, 3) == 0) begin
         mem_ack_i = 1'b1;  // stray ack while idle must be ignored
      end
   endtask

   // Requesters: hold the request through its rdy cycle, then drop it or
   // issue the next one.
   task automatic drive_random(input bit allow_new);
      start_i = allow_new ? ($urandom_range(0, 7) != 0) : 1'b1;
      if (e_if_rdy) begin
         if_done = 1'b1;
      end else begin
         if (if_done) begin if_req_i = 1'b0; if_done = 1'b0; end
         if (allow_new && !if_req_i && $urandom_range(0, 2) != 0) begin
            if_req_i  = 1'b1;
            if_addr_i = 32'h100 + 32'd4 * $urandom_range(0, 7);
         end
      end
      if (e_dm_rdy) begin
         dm_done = 1'b1;
      end else begin
         if (dm_done) begin dm_req_i = 1'b0; dm_done = 1'b0; end
         if (allow_new && !dm_req_i && $urandom_range(0, 2) == 0) begin
            dm_req_i   = 1'b1;
            dm_we_i    = $urandom_range(0, 1) == 1;
            dm_addr_i  = 32'h100 + 32'd4 * $urandom_range(0, 7);
            dm_wdata_i = $urandom;
         end
      end
   endtask

   initial begin
      int lat;
      bit got;

      // Reset values
      do_reset();

      // Single fetch at 0x10, ack one cycle after mem_req_o
      start_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h10; force_wait = 1;
      lat = 0; got = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (!got) begin
            tick();
            if (if_rdy_o === 1'b1) begin got = 1'b1; lat = i; end
         end
      end
      chk("if_latency", lat, 3);
      chk("if_fetch_data", if_data_o, mem_rd(32'h10));
      if_req_i = 1'b0;
      tick();

      // Simultaneous IF and DM write: DM first, IF granted in DM's rdy cycle
      force_wait = 0;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0; dm_wdata_i = 32'h5;
      if_req_i = 1'b1; if_addr_i = 32'h20;
      tick();
      chk("sim_dm_we",    mem_we_o,    1);
      chk("sim_dm_wdata", mem_wdata_o, 32'h5);
      chk("sim_dm_addr",  mem_addr_o,  32'h0);
      tick();
      chk("sim_dm_rdy",   dm_rdy_o, 1);
      chk("sim_stall",    stall_o,  1);
      dm_req_i = 1'b0;
      tick();
      chk("sim_if_gnt",   mem_addr_o, 32'h20);
      chk("sim_if_we",    mem_we_o,   0);
      chk("sim_stall_if", stall_o,    1);
      tick();
      chk("sim_if_rdy",   if_rdy_o, 1);
      if_req_i = 1'b0;
      tick();

      // DM read held high across its rdy pulse
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0;
      tick();
      tick();
      chk("hold_dm_rdy",   dm_rdy_o,   1);
      chk("hold_dm_rdata", dm_rdata_o, 32'h5);
      tick();
      chk("hold_no_dup",   mem_req_o,  0);
      tick();
      chk("hold_second",   mem_req_o,  1);
      tick();
      dm_req_i = 1'b0;
      tick();

      // start_i low during BUSY_DM: access completes, IF waits for start_i
      force_wait = 2;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h4;
      if_req_i = 1'b1; if_addr_i = 32'h8;
      tick();
      start_i = 1'b0;
      tick(); tick(); tick();
      chk("s0_dm_rdy",   dm_rdy_o,   1);
      chk("s0_dm_rdata", dm_rdata_o, mem_rd(32'h4));
      dm_req_i = 1'b0;
      tick(); tick();
      chk("s0_no_gnt",   mem_req_o,  0);
      start_i = 1'b1;
      tick();
      chk("s0_if_gnt",   mem_req_o,  1);
      chk("s0_if_addr",  mem_addr_o, 32'h8);
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!got) begin
            tick();
            if (if_rdy_o === 1'b1) got = 1'b1;
         end
      end
      chk("s0_if_done", got, 1);
      if_req_i = 1'b0;
      tick();

      // Reset in the middle of a fetch; the late ack is lost
      force_wait = 5;
      if_req_i = 1'b1; if_addr_i = 32'h30;
      tick();
      tick();
      #2;
      rst_i = 1'b0;
      #1;
      chk_reset_vals();
      if_req_i  = 1'b0;
      mem_ack_i = 1'b1;
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
      chk_reset_vals();
      rst_i = 1'b1;
      model_reset();
      tick();
      chk("rst_ack_lost", if_rdy_o,  0);
      chk("rst_idle",     mem_req_o, 0);

`ifdef ARB_PERF_EN
      // IF waits behind a DM access with 3 wait states
      force_wait = 3;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
      if_req_i = 1'b1; if_addr_i = 32'h44;
      for (int i = 0; i < 12; i++) begin
         drive_random(1'b0);
         tick();
      end
      chk("perf_if_cnt", if_wait_cnt_o, e_if_cnt);
`endif

      // Randomized traffic against the model
      force_wait = -1;
      for (int i = 0; i < 800; i++) begin
         drive_random(1'b1);
         tick();
      end
      for (int i = 0; i < 60; i++) begin
         drive_random(1'b0);
         tick();
      end
      chk("drained", {30'd0, if_req_i, dm_req_i}, 0);

`ifdef ARB_PERF_EN
      // Counter saturation
      start_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h50;
      tick();
      force dut.u_if_wait.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.u_if_wait.cnt_q;
      e_if_cnt = 32'hFFFF_FFFE;
      tick(); tick(); tick();
      chk("perf_sat", if_wait_cnt_o, 32'hFFFF_FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
